// File: rtl/shift_reg_seq.sv
// Multicycle entry-mux shift register: selects one of NSRC sources, then shifts/rotates it 1 bit/cycle.
// Define SHIFT_REG_SEQ_FAST_EN to replace the iterative shifter with a single-cycle barrel shifter.
module shift_reg_seq #(
  parameter  int WIDTH   = 32,
  parameter  int NSRC    = 3,
  localparam int SHAMT_W = $clog2(WIDTH),
  localparam int SEL_W   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SEL_W-1:0]        src_sel,
  input  logic [NSRC*WIDTH-1:0]   src_bus,
  input  logic [SHAMT_W-1:0]      shamt,
  input  logic [2:0]              op,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [WIDTH-1:0]        result
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("shift_reg_seq: WIDTH must be a power of 2 and at least 8");
  end
  if (NSRC < 2 || NSRC > 8) begin : g_bad_nsrc
    $error("shift_reg_seq: NSRC must be in 2..8");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [2:0]         op_q, op_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   sel_data;
  logic               sel_valid;
  logic               op_valid;

  // One-bit step of the iterative shifter; unknown opcodes never reach SHIFT.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input logic [2:0] o);
    case (o)
      OP_SLL:  step = {d[WIDTH-2:0], 1'b0};
      OP_SRL:  step = {1'b0, d[WIDTH-1:1]};
      OP_SRA:  step = {d[WIDTH-1], d[WIDTH-1:1]};
      OP_ROR:  step = {d[0], d[WIDTH-1:1]};
      default: step = d;
    endcase
  endfunction

`ifdef SHIFT_REG_SEQ_FAST_EN
  function automatic logic [WIDTH-1:0] barrel(input logic [WIDTH-1:0] d,
                                              input logic [2:0]       o,
                                              input logic [SHAMT_W-1:0] s);
    logic [2*WIDTH-1:0] rot;
    rot = {d, d} >> s;
    case (o)
      OP_SLL:  barrel = d << s;
      OP_SRL:  barrel = d >> s;
      OP_SRA:  barrel = $signed(d) >>> s;
      OP_ROR:  barrel = rot[WIDTH-1:0];
      default: barrel = d;
    endcase
  endfunction
`endif

  // Out-of-range selects fall through the loop and leave sel_data at zero.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (int'(src_sel) == i) sel_data = src_bus[i*WIDTH +: WIDTH];
    end
  end

  assign sel_valid = int'(src_sel) < NSRC;
  assign op_valid  = op <= OP_ROR;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          op_d    = op;
          count_d = shamt;
          err_d   = !sel_valid || !op_valid;
`ifdef SHIFT_REG_SEQ_FAST_EN
          data_d  = barrel(sel_data, op, shamt);
          state_d = S_DONE;
`else
          data_d  = sel_data;
          if (!op_valid || op == OP_LOAD || shamt == '0) state_d = S_DONE;
          else                                            state_d = S_SHIFT;
`endif
        end
      end
      S_SHIFT: begin
        data_d  = step(data_q, op_q);
        count_d = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      op_q    <= OP_LOAD;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign busy   = (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);
  assign err    = err_q;
  assign result = data_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Self-checking bench for shift_reg_seq: directed test-plan scenarios plus randomized operations
// checked against an arithmetic reference model.
module tb_shift_reg_seq;
  localparam int WIDTH = 32;
  localparam int NSRC  = 3;

  logic                  clk;
  logic                  reset;
  logic                  start;
  logic [1:0]            src_sel;
  logic [NSRC*WIDTH-1:0] src_bus;
  logic [4:0]            shamt;
  logic [2:0]            op;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [WIDTH-1:0]      result;

  logic [WIDTH-1:0] src [NSRC];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  shift_reg_seq #(.WIDTH(WIDTH), .NSRC(NSRC)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .src_sel (src_sel),
    .src_bus (src_bus),
    .shamt   (shamt),
    .op      (op),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result from the operation's arithmetic meaning.
  function automatic logic [31:0] ref_result(input logic [31:0] x, input int o, input int k);
    case (o)
      1: return x << k;
      2: return x >> k;
      3: return x[31] ? ~((~x) >> k) : (x >> k);
      4: return (k == 0) ? x : ((x >> k) | (x << (32 - k)));
      default: return x;
    endcase
  endfunction

  // Cycles from the accepting edge to the done cycle.
  function automatic int ref_latency(input int o, input int k);
`ifdef SHIFT_REG_SEQ_FAST_EN
    return 1;
`else
    return (o >= 1 && o <= 4 && k != 0) ? k + 1 : 1;
`endif
  endfunction

  // Called right after a negedge; drives a start, then watches until done.
  // With chain set, returns at the done cycle so the caller can start again from DONE.
  task automatic run_op(input string tag, input int sel, input int o, input int k, input bit chain);
    logic [31:0] x;
    logic [31:0] exp_res;
    int lat, c, busy_cnt, done_at;
    x       = (sel < NSRC) ? src[sel] : 32'h0;
    exp_res = ref_result(x, o, k);
    lat     = ref_latency(o, k);
    src_bus = {src[2], src[1], src[0]};
    src_sel = sel[1:0];
    op      = o[2:0];
    shamt   = k[4:0];
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    src_sel = 2'($urandom);
    op      = 3'($urandom);
    shamt   = 5'($urandom);
    src_bus = {$urandom, $urandom, $urandom};
    c = 1; busy_cnt = 0; done_at = 0;
    while (c <= 80) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_at = c;
        break;
      end
      @(negedge clk);
      c++;
    end
    check({tag, " done_cycle"}, done_at, lat);
    check({tag, " busy_cycles"}, busy_cnt, lat - 1);
    check({tag, " result"}, result, exp_res);
    check({tag, " err"}, err, (sel >= NSRC || o > 4) ? 1 : 0);
    if (!chain) begin
      @(negedge clk);
      check({tag, " done_one_pulse"}, done, 1'b0);
      check({tag, " result_held"}, result, exp_res);
    end
  endtask

  initial begin
    int dcnt, bcnt;
    reset = 1'b1; start = 1'b0; src_sel = '0; op = '0; shamt = '0; src_bus = '0;
    for (int i = 0; i < NSRC; i++) src[i] = '0;
    repeat (2) @(negedge clk);
    check("reset result", result, 32'h0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset err", err, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("idle done", done, 1'b0);

    src[0] = 32'h1234_5678; src[1] = 32'h0000_00F0; src[2] = 32'h0000_0001;
    run_op("sll4", 1, 1, 4, 0);
    check("sll4 const", result, 32'h0000_0F00);

    src[0] = 32'h8000_0000;
    run_op("sra31", 0, 3, 31, 0);
    check("sra31 const", result, 32'hFFFF_FFFF);
    run_op("srl31", 0, 2, 31, 0);
    check("srl31 const", result, 32'h0000_0001);

    run_op("ror1", 2, 4, 1, 0);
    check("ror1 const", result, 32'h8000_0000);
    run_op("ror0", 2, 4, 0, 0);
    check("ror0 const", result, 32'h0000_0001);

    run_op("badsel", 3, 1, 2, 0);
    check("badsel const", result, 32'h0);
    src[0] = 32'hCAFE_F00D;
    run_op("badop", 0, 6, 9, 0);
    check("badop const", result, 32'hCAFE_F00D);

    run_op("chain_a", 2, 1, 3, 1);
    run_op("chain_b", 0, 2, 5, 0);
    run_op("load", 1, 0, 7, 0);

`ifndef SHIFT_REG_SEQ_FAST_EN
    // Start pulsed mid-shift must be ignored and not queued.
    src[0] = 32'h0000_00A5; src_bus = {src[2], src[1], src[0]};
    src_sel = 2'd0; op = 3'd1; shamt = 5'd8; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; src_sel = 2'd2; op = 3'd2; shamt = 5'd3;
    @(negedge clk); start = 1'b0;
    dcnt = 0;
    for (int c = 3; c <= 12; c++) begin
      if (done === 1'b1 && dcnt == 0) begin
        dcnt = c;
        check("ignored_start result", result, 32'h0000_A500);
      end
      @(negedge clk);
    end
    check("ignored_start done_cycle", dcnt, 9);
    check("ignored_start idle busy", busy, 1'b0);
    check("ignored_start idle done", done, 1'b0);
`endif

    // Asynchronous reset in the middle of a shift.
    src[1] = 32'h0F0F_0F0F; src_bus = {src[2], src[1], src[0]};
    src_sel = 2'd1; op = 3'd1; shamt = 5'd10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midreset result", result, 32'h0);
    check("midreset busy", busy, 1'b0);
    check("midreset done", done, 1'b0);
    check("midreset err", err, 1'b0);
    @(negedge clk); reset = 1'b0;
    dcnt = 0; bcnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
      if (busy === 1'b1) bcnt++;
    end
    check("midreset no_done", dcnt, 0);
    check("midreset no_busy", bcnt, 0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NSRC; i++) src[i] = $urandom;
      if (n % 5 == 0) src[$urandom_range(0, NSRC - 1)][31] = 1'b1;
      run_op($sformatf("rnd%0d", n), $urandom_range(0, 3), $urandom_range(0, 7),
             $urandom_range(0, 31), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
